// File: rtl/prime_pkg.sv
// Shared widths, FSM encoding and constants for the prime sweep controller
// and its trial-division checker.
package prime_pkg;
    localparam int NUM_W_DEF = 10;
    localparam int CNT_W_DEF = 8;

    // First candidate of a sweep and first trial divisor.
    localparam int FIRST_VAL = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TEST,
        NEXT,
        DONE
    } state_e;
endpackage

// File: rtl/prime_trial_div.sv
// Iterative trial-division primality checker: one subtraction per cycle,
// divisors 2,3,... until d*d > n (prime) or an exact division (composite).
module prime_trial_div
    import prime_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             go,
    input  logic             abort,
    input  logic [NUM_W-1:0] n,
    output logic             valid,
    output logic             is_prime
);
    logic             run_q, run_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic [NUM_W-1:0] d_q, d_d;
    logic [NUM_W-1:0] r_q, r_d;
    logic             valid_q, valid_d;
    logic             prime_q, prime_d;

    logic [2*NUM_W-1:0] sq;
    logic [2*NUM_W-1:0] n_ext;

    assign sq    = {{NUM_W{1'b0}}, d_q} * {{NUM_W{1'b0}}, d_q};
    assign n_ext = {{NUM_W{1'b0}}, n_q};

    always_comb begin
        run_d   = run_q;
        n_d     = n_q;
        d_d     = d_q;
        r_d     = r_q;
        valid_d = 1'b0;
        prime_d = prime_q;
        if (abort) begin
            run_d = 1'b0;
        end else if (go) begin
            run_d = 1'b1;
            n_d   = n;
            d_d   = NUM_W'(FIRST_VAL);
            r_d   = n;
        end else if (run_q) begin
            if (sq > n_ext) begin
                valid_d = 1'b1;
                prime_d = 1'b1;
                run_d   = 1'b0;
            end else if (r_q == '0) begin
                // d*d <= n with d >= 2 already implies d < n
                valid_d = 1'b1;
                prime_d = 1'b0;
                run_d   = 1'b0;
            end else if (r_q < d_q) begin
                d_d = d_q + NUM_W'(1);
                r_d = n_q;
            end else begin
                r_d = r_q - d_q;
            end
        end
    end

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            run_q   <= 1'b0;
            n_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            n_q     <= n_d;
            d_q     <= d_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            prime_q <= prime_d;
        end
    end

    assign valid    = valid_q;
    assign is_prime = prime_q;
endmodule

// File: rtl/prime_sweep_ctrl.sv
// Sweeps candidates 2..NumMax through one trial-division checker, pulsing
// Prime per prime found and keeping a saturating prime count.
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [NUM_W-1:0] NumMax,
    output logic             Busy,
    output logic             Done,
    output logic             Prime,
    output logic [NUM_W-1:0] NumberChecked,
    output logic [CNT_W-1:0] NumberofPrimesFound,
    output logic             Overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [NUM_W-1:0] max_q;
    logic [NUM_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             prime_q;
    logic             go_q;

    logic chk_valid;
    logic chk_prime;
    logic chk_abort;

    // Busy is high exactly in LOAD/TEST/NEXT, the states where Abort acts.
    assign chk_abort = Abort & busy_q;

    prime_trial_div #(.NUM_W(NUM_W)) u_chk (
        .SysClk   (SysClk),
        .Reset    (Reset),
        .go       (go_q),
        .abort    (chk_abort),
        .n        (num_q),
        .valid    (chk_valid),
        .is_prime (chk_prime)
    );

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            max_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prime_q <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            go_q    <= 1'b0;
            prime_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        max_q   <= NumMax;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (max_q < NUM_W'(FIRST_VAL)) begin
                        num_q   <= max_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        num_q   <= NUM_W'(FIRST_VAL);
                        go_q    <= 1'b1;
                        state_q <= TEST;
                    end
                end
                TEST: begin
                    // Abort beats a same-cycle result: no pulse, no count.
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (chk_valid) begin
                        if (chk_prime) begin
                            prime_q <= 1'b1;
                            if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
                            else                  cnt_q <= cnt_q + CNT_W'(1);
                        end
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (num_q == max_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        num_q   <= num_q + NUM_W'(1);
                        go_q    <= 1'b1;
                        state_q <= TEST;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy                = busy_q;
    assign Done                = done_q;
    assign Prime               = prime_q;
    assign NumberChecked       = num_q;
    assign NumberofPrimesFound = cnt_q;
    assign Overflow            = ovf_q;
endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl: a wide instance (10/8) and a narrow one (6/4)
// for the no-wrap and count-saturation corners, each with its own model.
module tb_prime_sweep_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit fin0 = 1'b0;
    bit fin1 = 1'b0;

    function automatic bit is_pr(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pi_of(int n);
        int c = 0;
        for (int i = 2; i <= n; i++) if (is_pr(i)) c++;
        return c;
    endfunction

    function automatic int next_pr(int n);
        int m = n + 1;
        while (!is_pr(m)) m++;
        return m;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    for (genvar G = 0; G < 2; G++) begin : g
        localparam int NW  = (G == 0) ? 10 : 6;
        localparam int CW  = (G == 0) ? 8 : 4;
        localparam int SAT = (1 << CW) - 1;
        localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;

        logic          rst_n, start, abort;
        logic [NW-1:0] nmax;
        logic          busy, done, prime, ovf;
        logic [NW-1:0] num;
        logic [CW-1:0] cnt;

        prime_sweep_ctrl #(.NUM_W(NW), .CNT_W(CW)) dut (
            .SysClk              (clk),
            .Reset               (rst_n),
            .Start               (start),
            .Abort               (abort),
            .NumMax              (nmax),
            .Busy                (busy),
            .Done                (done),
            .Prime               (prime),
            .NumberChecked       (num),
            .NumberofPrimesFound (cnt),
            .Overflow            (ovf)
        );

        // model: sweep phase, latched bound, pulses seen, last prime pulsed
        int phase, mmax, k, lastp, mnum, prev_num;

        function automatic int ecnt(int kk);
            return (kk > SAT) ? SAT : kk;
        endfunction

        task automatic c(string nm, logic [31:0] a, logic [31:0] e);
            chk($sformatf("u%0d_%s", G, nm), a, e);
        endtask

        task automatic check_hold(string tag);
            c({tag, "_busy"}, 32'(busy), 32'(phase == P_BUSY));
            c({tag, "_done"}, 32'(done), 32'(phase == P_DONE));
            c({tag, "_prime"}, 32'(prime), 0);
            c({tag, "_num"}, 32'(num), mnum);
            c({tag, "_cnt"}, 32'(cnt), ecnt(k));
            c({tag, "_ovf"}, 32'(ovf), 32'(k > SAT));
        endtask

        initial begin : mon
            bit s_st, s_ab, s_rst;
            int s_nm;
            phase = P_IDLE; k = 0; lastp = 1; mnum = 0; mmax = 0; prev_num = 0;
            forever begin
                @(posedge clk);
                s_st = start; s_ab = abort; s_rst = rst_n; s_nm = int'(nmax);
                @(negedge clk);
                if (!rst_n) begin
                    phase = P_IDLE; k = 0; lastp = 1; mnum = 0;
                    check_hold("rst");
                end else begin
                    if (s_rst) begin
                        if (phase != P_BUSY && s_st) begin
                            phase = P_BUSY; mmax = s_nm; k = 0; lastp = 1;
                        end else if (phase == P_BUSY && s_ab) begin
                            phase = P_IDLE; mnum = prev_num;
                        end
                    end
                    if (phase != P_BUSY) begin
                        check_hold("hold");
                    end else if (done) begin
                        c("fin_busy", 32'(busy), 0);
                        c("fin_prime", 32'(prime), 0);
                        c("fin_num", 32'(num), mmax);
                        c("fin_pulses", k, pi_of(mmax));
                        c("fin_cnt", 32'(cnt), ecnt(k));
                        c("fin_ovf", 32'(ovf), 32'(k > SAT));
                        phase = P_DONE; mnum = mmax;
                    end else begin
                        c("run_busy", 32'(busy), 1);
                        if (prime) begin
                            c("prime_num", 32'(num), next_pr(lastp));
                            c("prime_le_max", 32'(int'(num) <= mmax), 1);
                            k++;
                            lastp = int'(num);
                        end
                        c("run_cnt", 32'(cnt), ecnt(k));
                        c("run_ovf", 32'(ovf), 32'(k > SAT));
                        prev_num = int'(num);
                    end
                end
            end
        end

        task automatic do_start(int m);
            @(negedge clk);
            nmax  = m[NW-1:0];
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        // Waits for Done; with noise, pulses Start and scrambles NumMax meanwhile.
        task automatic wait_done(int limit, bit noisy);
            for (int i = 0; i < limit; i++) begin
                if (done) break;
                @(negedge clk);
                if (noisy && !done) begin
                    start = ($urandom_range(0, 15) == 0);
                    nmax  = NW'($urandom);
                end
            end
            start = 1'b0;
            c("done_reached", 32'(done), 1);
        endtask

        task automatic wait_num(int target, int limit);
            for (int i = 0; i < limit; i++) begin
                if (int'(num) == target) break;
                @(negedge clk);
            end
            c("num_reached", 32'(num), target);
        endtask

        task automatic hard_reset();
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            @(posedge clk);
            #2 rst_n = 1'b1;
        endtask

        if (G == 0) begin : sa
            initial begin
                int m, tg, held;
                start = 1'b0; abort = 1'b0; nmax = '0;
                hard_reset();

                do_start(2);   wait_done(2000, 1'b0);
                c("m2_cnt", 32'(cnt), 1); c("m2_pulses", k, 1); c("m2_lastp", lastp, 2);
                do_start(1);   wait_done(2000, 1'b0);
                c("m1_cnt", 32'(cnt), 0); c("m1_num", 32'(num), 1); c("m1_pulses", k, 0);
                do_start(0);   wait_done(2000, 1'b0);
                c("m0_num", 32'(num), 0); c("m0_done", 32'(done), 1);

                for (int r = 0; r < 2; r++) begin
                    m = $urandom_range(3, 120);
                    do_start(m); wait_done(40000, 1'b1);
                    c("rnd_cnt", 32'(cnt), ecnt(pi_of(m)));
                    c("rnd_num", 32'(num), m);
                end

                do_start(200);
                tg = $urandom_range(20, 60);
                wait_num(tg, 20000);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                held = int'(num);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                c("abort_busy", 32'(busy), 0);
                c("abort_done", 32'(done), 0);
                c("abort_num", 32'(num), held);
                c("abort_cnt_range", 32'(int'(cnt) == pi_of(held) || int'(cnt) == pi_of(held - 1)), 1);
                abort = 1'b1;
                repeat (3) @(negedge clk);
                abort = 1'b0;

                do_start(100); wait_done(40000, 1'b0);
                c("m100_cnt", 32'(cnt), 25); c("m100_num", 32'(num), 100);
                c("m100_ovf", 32'(ovf), 0);  c("m100_pulses", k, 25);
                abort = 1'b1;
                repeat (2) @(negedge clk);
                abort = 1'b0;
                c("abort_in_done", 32'(done), 1);

                do_start(200);
                wait_num(40, 20000);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                c("arst_busy", 32'(busy), 0);  c("arst_done", 32'(done), 0);
                c("arst_prime", 32'(prime), 0); c("arst_num", 32'(num), 0);
                c("arst_cnt", 32'(cnt), 0);    c("arst_ovf", 32'(ovf), 0);
                @(posedge clk);
                #2 rst_n = 1'b1;

                do_start(10); wait_done(20000, 1'b0);
                c("m10_cnt", 32'(cnt), 4); c("m10_num", 32'(num), 10);
                fin0 = 1'b1;
            end
        end else begin : sb
            initial begin
                start = 1'b0; abort = 1'b0; nmax = '0;
                hard_reset();
                do_start(63); wait_done(40000, 1'b1);
                c("m63_cnt", 32'(cnt), 15);   c("m63_ovf", 32'(ovf), 1);
                c("m63_num", 32'(num), 63);   c("m63_lastp", lastp, 61);
                c("m63_pulses", k, 18);
                do_start(20); wait_done(20000, 1'b0);
                c("m20_cnt", 32'(cnt), 8);    c("m20_ovf", 32'(ovf), 0);
                fin1 = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (fin0 && fin1);
            #900000;
        join_any
        if (!(fin0 && fin1)) begin
            checks++;
            failures++;
            $display("FAIL global_timeout actual=%0d required=1", fin0 && fin1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prime_sweep_ctrl.md
Name: prime_sweep_ctrl

Overview:
Sequencing controller for the prime-search datapath.
- Accepts a start command with an upper bound NumMax and walks candidates 2..NumMax through one iterative trial-division checker.
- Pulses Prime for each prime found and keeps a running prime count.
- Signals completion with Done; sits between the system/host control logic and the prime checker.

Parameters:
NUM_W, 10, width of NumMax and NumberChecked (candidates 0..2^NUM_W-1)
CNT_W, 8, width of NumberofPrimesFound; count saturates at 2^CNT_W-1

Ports:
SysClk  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset; one clock domain only
Start  input  1  command strobe; sampled only in IDLE or DONE
Abort  input  1  cancels a running sweep
NumMax  input  NUM_W  inclusive upper bound; latched when Start is accepted
Busy  output  1  high while a sweep is in progress
Done  output  1  level, high in DONE until the next accepted Start
Prime  output  1  one-cycle pulse; NumberChecked is prime
NumberChecked  output  NUM_W  candidate currently or last tested
NumberofPrimesFound  output  CNT_W  primes found in the current or last sweep
Overflow  output  1  sticky; count saturated during this sweep

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs are 0: Busy, Done, Prime, NumberChecked, NumberofPrimesFound, Overflow.
  - Reset mid-sweep discards all progress. The checker sub-module resets too.
- States: IDLE, LOAD, TEST, NEXT, DONE.
- IDLE/DONE with Start=1:
  - Latch NumMax into max_r.
  - Clear the count and Overflow; drop Done.
  - Go to LOAD and assert Busy.
  - Start is ignored in LOAD, TEST and NEXT.
- LOAD:
  - If max_r < 2: go to DONE on the next cycle with count 0 and no Prime pulse. NumberChecked is set to max_r.
  - Otherwise set NumberChecked=2, pulse go to the checker and enter TEST.
- TEST: wait for the checker's valid.
  - If is_prime, pulse Prime on the cycle after valid, together with the count update.
  - Count increments by 1 per prime. At 2^CNT_W-1 it holds and sets Overflow.
  - Then enter NEXT.
- NEXT:
  - If NumberChecked == max_r, go to DONE: Busy=0, Done=1.
  - Otherwise increment NumberChecked and pulse go in the same cycle. Go back to TEST.
  - NumberChecked never wraps. When max_r = 2^NUM_W-1, the terminal compare happens before the increment.
- DONE: outputs hold their values; Done stays high until Start or Reset.
- Abort in LOAD, TEST or NEXT:
  - Go to IDLE the next cycle. Busy=0 and Done stays 0.
  - Count, NumberChecked and Overflow hold their last values.
  - The checker is cleared via its abort input.
  - If Abort and checker valid arrive in the same cycle, Abort wins: no Prime pulse and no count update.
  - Abort in IDLE or DONE has no effect.
- NumMax changes while Busy are ignored; only the latched max_r is used.
- Latency:
  - Per candidate, latency depends on the data and is bounded by the checker.
  - There is 1 cycle of NEXT overhead per candidate.
  - Done rises 1 cycle after the last result is handled.
- Checker contract (prime_trial_div):
  - go pulse with n.
  - The checker tries divisors d=2,3,… and computes each remainder by repeated subtraction, one per cycle.
  - It stops with is_prime=1 when d*d > n.
  - It stops with is_prime=0 when the remainder is 0 and d < n.
  - It returns one valid pulse with is_prime. n=2 and n=3 are prime.

Decomposition:
- Shared package prime_pkg holds:
  - NUM_W and CNT_W defaults.
  - The state encoding constants (IDLE, LOAD, TEST, NEXT, DONE).
  - The constant 2 as the first candidate and first divisor.
- One sub-module, prime_trial_div, with ports SysClk, Reset, go, abort, n, valid, is_prime. It is instantiated once.
- prime_sweep_ctrl holds the FSM, bound latch, candidate counter and prime counter.

Test Plan:
- NumMax=1000, Start pulse → Busy until Done; NumberofPrimesFound=168, 168 Prime pulses, NumberChecked=1000, Overflow=0.
- NumMax=2 → exactly one Prime pulse with NumberChecked=2; Done with count=1. Then NumMax=1 with Start → Done, count=0, no Prime pulse.
- NumMax=1023 → count=172; last Prime pulse at NumberChecked=1021; no wrap, Done asserted.
- Abort asserted when NumberChecked=500 → Busy=0 next cycle, Done=0, count holds 95. Restart with NumMax=100 → count=25, Done=1.
- Reset driven low mid-sweep at NumberChecked≈300 → all outputs 0 immediately (async), IDLE; Start with NumMax=10 → count=4.
- CNT_W=4, NumMax=100 → count saturates at 15, Overflow=1, Done=1; Start while Busy is ignored (no restart, count unaffected).
